alu8_reg: RTL and testbench

- 8-bit, 16-function arithmetic/logic unit with a registered result.
- Operands A and B plus a 4-bit opcode CTR are sampled on the rising edge of ck. The result is presented on O one cycle later.
- Used as the datapath ALU of the small processor/lab designs.
- Drivers change A/B/CTR on the falling edge; the block captures on the rising edge.

---
 rtl/alu8_pkg.sv | 51 +++++
 rtl/alu8_comb.sv | 109 ++++++++++
 rtl/alu8_reg.sv | 64 ++++++
 tb/tb_alu8_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// Shared opcode constants, opcode enum and flag bit positions for the alu8 datapath ALU.
// The optional flags output (macro ALU_FLAGS_EN) uses the FLG_* indices and the overflow helper.
package alu8_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;
    localparam logic [3:0] OP_ROR  = 4'hC;
    localparam logic [3:0] OP_NOT  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_SLTU = 4'hF;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_NAND = 4'h6,
        ALU_XNOR = 4'h7,
        ALU_SHL  = 4'h8,
        ALU_SHR  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_ROL  = 4'hB,
        ALU_ROR  = 4'hC,
        ALU_NOT  = 4'hD,
        ALU_INC  = 4'hE,
        ALU_SLTU = 4'hF
    } alu_op_t;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Two's-complement overflow of x+y: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

endpackage

// File: rtl/alu8_comb.sv
// Combinational 16-function ALU core: next result (and, with ALU_FLAGS_EN, next {N,Z,C,V}).
// Arithmetic is modulo 2^WIDTH; shift/rotate amount is the low log2(WIDTH) bits of B.
module alu8_comb
    import alu8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_ctr,
    output logic [WIDTH-1:0] o_res
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       o_flags
`endif
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]         w_sh;
    logic signed [WIDTH-1:0] w_a_s;
    logic [2*WIDTH-1:0]     w_rol;
    logic [2*WIDTH-1:0]     w_ror;
    alu_op_t                w_op;

    assign w_sh  = i_b[SHW-1:0];
    assign w_a_s = i_a;
    assign w_op  = alu_op_t'(i_ctr);

    // Rotates: shift a doubled copy of A and keep the half that wrapped around.
    assign w_rol = {i_a, i_a} << w_sh;
    assign w_ror = {i_a, i_a} >> w_sh;

    always_comb begin
        case (w_op)
            ALU_ADD:  o_res = i_a + i_b;
            ALU_SUB:  o_res = i_a - i_b;
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_XOR:  o_res = i_a ^ i_b;
            ALU_NOR:  o_res = ~(i_a | i_b);
            ALU_NAND: o_res = ~(i_a & i_b);
            ALU_XNOR: o_res = ~(i_a ^ i_b);
            ALU_SHL:  o_res = i_a << w_sh;
            ALU_SHR:  o_res = i_a >> w_sh;
            ALU_SRA:  o_res = w_a_s >>> w_sh;
            ALU_ROL:  o_res = w_rol[2*WIDTH-1:WIDTH];
            ALU_ROR:  o_res = w_ror[WIDTH-1:0];
            ALU_NOT:  o_res = ~i_a;
            ALU_INC:  o_res = i_a + WIDTH'(1);
            ALU_SLTU: o_res = WIDTH'(i_a < i_b);
            default:  o_res = 'x;
        endcase
    end

`ifdef ALU_FLAGS_EN
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_shl_mask;
    logic [WIDTH-1:0] w_shr_mask;
    logic             w_add_c;
    logic             w_shl_c;
    logic             w_shr_c;
    logic             w_c;
    logic             w_v;

    // Masks select the last bit shifted out: A[WIDTH-sh] left, A[sh-1] right; none when sh=0.
    assign w_shl_mask = (w_sh == '0) ? '0 : (MSB_ONE >> (w_sh - SHW'(1)));
    assign w_shr_mask = (w_sh == '0) ? '0 : (WIDTH'(1) << (w_sh - SHW'(1)));
    assign w_shl_c    = |(i_a & w_shl_mask);
    assign w_shr_c    = |(i_a & w_shr_mask);
    assign w_add_c    = (i_a + i_b) < i_a;

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_c = w_add_c;
                w_v = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], o_res[WIDTH-1]);
            end
            ALU_SUB: begin
                w_c = i_a < i_b;
                w_v = add_ovf(i_a[WIDTH-1], ~i_b[WIDTH-1], o_res[WIDTH-1]);
            end
            ALU_INC: begin
                w_c = &i_a;
                w_v = add_ovf(i_a[WIDTH-1], 1'b0, o_res[WIDTH-1]);
            end
            ALU_SHL: w_c = w_shl_c;
            ALU_SHR: w_c = w_shr_c;
            ALU_SRA: w_c = w_shr_c;
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_flags        = '0;
        o_flags[FLG_N] = o_res[WIDTH-1];
        o_flags[FLG_Z] = (o_res == '0);
        o_flags[FLG_C] = w_c;
        o_flags[FLG_V] = w_v;
    end
`endif

endmodule

// File: rtl/alu8_reg.sv
// Registered 16-function ALU: A/B/CTR captured on rising ck, result on O one cycle later.
// Define ALU_FLAGS_EN to add the registered FLAGS[3:0] = {N,Z,C,V} output.
module alu8_reg
    import alu8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] O,
    input  logic [3:0]       CTR,
    input  logic             ck,
    input  logic             rst_n
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       FLAGS
`endif
);

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_o;

`ifdef ALU_FLAGS_EN
    logic [3:0] w_flags;
    logic [3:0] r_flags;
`endif

    alu8_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_a     (A),
        .i_b     (B),
        .i_ctr   (CTR),
        .o_res   (w_res)
`ifdef ALU_FLAGS_EN
        ,
        .o_flags (w_flags)
`endif
    );

    // Output stage: no enable, reset clears the in-flight result immediately.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_o <= '0;
        end else begin
            r_o <= w_res;
        end
    end

    assign O = r_o;

`ifdef ALU_FLAGS_EN
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags;
        end
    end

    assign FLAGS = r_flags;
`endif

endmodule

// File: tb/tb_alu8_reg.sv
// Scoreboard bench for alu8_reg: expected results queued at issue, popped by a monitor after each capture.
// With ALU_FLAGS_EN defined the FLAGS output is checked as well.
module tb_alu8_reg;
    import alu8_pkg::*;

    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] O;
    logic [3:0] CTR;
    logic       ck;
    logic       rst_n;
    logic       tb_vld;
`ifdef ALU_FLAGS_EN
    logic [3:0] FLAGS;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] o;
        logic [3:0] f;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu8_reg #(.WIDTH(8)) dut (
        .A     (A),
        .B     (B),
        .O     (O),
        .CTR   (CTR),
        .ck    (ck),
        .rst_n (rst_n)
`ifdef ALU_FLAGS_EN
        ,
        .FLAGS (FLAGS)
`endif
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   sh;
        int   sa;
        int   sb;
        int   r;
        int   sr;
        bit   c;
        bit   v;
        sh = b % 8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            0:  begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            1:  begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~(a | b);
            6:  r = ~(a & b);
            7:  r = ~(a ^ b);
            8:  begin r = a << sh; c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
            9:  begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            10: begin r = sa >>> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            11: r = (a << sh) | (a >> (8 - sh));
            12: r = (a >> sh) | (a << (8 - sh));
            13: r = ~a;
            14: begin r = a + 1; c = (r > 255); v = (sa + 1 > 127); end
            default: r = (a < b) ? 1 : 0;
        endcase
        r    = r & 255;
        e.a  = a[7:0];
        e.b  = b[7:0];
        e.op = op[3:0];
        e.o  = r[7:0];
        e.f  = {(r >= 128), (r == 0), c, v};
        return e;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        @(negedge ck);
        A      = a;
        B      = b;
        CTR    = op;
        tb_vld = 1'b1;
        exp_q.push_back(model(int'(a), int'(b), int'(op)));
    endtask

    task automatic idle();
        @(negedge ck);
        tb_vld = 1'b0;
    endtask

    task automatic check_reset(input string name);
        n_vec++;
`ifdef ALU_FLAGS_EN
        if (O !== 8'h00 || FLAGS !== 4'h0) begin
            n_err++;
            $display("FAIL %s: O=%h FLAGS=%h, required O=00 FLAGS=0", name, O, FLAGS);
        end
`else
        if (O !== 8'h00) begin
            n_err++;
            $display("FAIL %s: O=%h, required 00", name, O);
        end
`endif
    endtask

    // Monitor: a vector valid at a rising edge is compared just after that edge.
    initial begin
        logic v;
        exp_t e;
        forever begin
            @(posedge ck);
            v = tb_vld;
            #1;
            if (v) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_underflow: O=%h with no expected entry", O);
                end else begin
                    e = exp_q.pop_front();
`ifdef ALU_FLAGS_EN
                    if (O !== e.o || FLAGS !== e.f) begin
                        n_err++;
                        $display("FAIL op%h A=%h B=%h: O=%h FLAGS=%h, required O=%h FLAGS=%h",
                                 e.op, e.a, e.b, O, FLAGS, e.o, e.f);
                    end
`else
                    if (O !== e.o) begin
                        n_err++;
                        $display("FAIL op%h A=%h B=%h: O=%h, required %h", e.op, e.a, e.b, O, e.o);
                    end
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        A      = 8'h00;
        B      = 8'h00;
        CTR    = 4'h0;
        tb_vld = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset("reset_initial");
        repeat (2) @(posedge ck);
        @(negedge ck) rst_n = 1'b1;

        issue(8'h03, 8'h04, OP_ADD);
        issue(8'hFF, 8'h01, OP_ADD);
        issue(8'h00, 8'h01, OP_SUB);
        issue(8'h7F, 8'h00, OP_INC);
        issue(8'hFF, 8'h37, OP_INC);
        issue(8'h80, 8'h01, OP_SUB);
        issue(8'h7F, 8'h01, OP_ADD);
        for (int i = 2; i <= 7; i++) issue(8'hF0, 8'h3C, 4'(i));
        issue(8'hF0, 8'h3C, OP_NOT);
        for (int i = 8; i <= 12; i++) issue(8'h81, 8'h01, 4'(i));
        for (int i = 8; i <= 12; i++) issue(8'h81, 8'h08, 4'(i));
        issue(8'hB5, 8'h07, OP_SHL);
        issue(8'hB5, 8'h07, OP_SRA);
        issue(8'h01, 8'hFF, OP_SLTU);
        issue(8'hFF, 8'h01, OP_SLTU);
        issue(8'h10, 8'h10, OP_SLTU);

        // Mid-cycle reset with a result held on O.
        issue(8'h5A, 8'h00, OP_ADD);
        idle();
        @(posedge ck);
        #3 rst_n = 1'b0;
        #1 check_reset("reset_async_midcycle");
        @(posedge ck);
        #1 check_reset("reset_held_over_edge");
        @(negedge ck) rst_n = 1'b1;
        issue(8'h03, 8'h04, OP_ADD);

        // Back-to-back random vectors, one per cycle.
        for (int i = 0; i < 16; i++)
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
        for (int i = 0; i < 48; i++)
            issue(8'($urandom), 8'($urandom), 4'($urandom));

        idle();
        repeat (3) @(posedge ck);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
